tdc_frame_streamer: RTL and testbench
=====================================

// Module: tdc_frame_streamer
// PURPOSE
//   Parametrised TDC snapshot streamer. Generates the periodic sample tick, captures a
//   DATASIZE-bit delayline snapshot and sends it as a framed UART packet.
//   Each packet carries a header, a sequence number, the data bytes and an XOR checksum.
//   Sits between the delayline capture register and the existing uart_tx byte transmitter.
//   Detects and counts sample ticks lost while a packet is still in flight.
// PARAMETERS
//   DATASIZE     64        snapshot width; multiple of 8, range 8..256; NBYTES = DATASIZE/8
//   SYSTEM_FREQ  10000000  clk10m frequency in Hz
//   TARGET_FREQ  30        sample tick rate in Hz; TICK_DIV = SYSTEM_FREQ/TARGET_FREQ, >= 2
//   HEADER       8'hA5     first byte of every packet
// PORTS
//   clk10m       in   1         system clock, 10 MHz
//   rst_n        in   1         reset, asynchronous, active-low
//   enable       in   1         1 = start packets on sample ticks
//   snap_d       in   DATASIZE  delayline snapshot; quasi-static, sampled in CAPTURE
//   sample_tick  out  1         one-cycle pulse at TARGET_FREQ; drives the external capture clock
//   tx_push      out  1         one-cycle request to uart_tx
//   tx_byte      out  8         byte for uart_tx; stable from tx_push until tx_done
//   tx_done      in   1         one-cycle pulse from uart_tx: byte finished
//   busy         out  1         1 whenever state != IDLE
//   overrun_cnt  out  8         saturating count of discarded ticks
// BEHAVIOUR
//   Reset
//   - Every output, the divider, seq, index and checksum are 0; the state is IDLE.
//   - Reset is legal mid-packet: the frame is abandoned and seq is not incremented.
//   Divider
//   - The counter runs 0..TICK_DIV-1 and wraps, regardless of enable.
//   - sample_tick is registered and high for the one cycle in which the counter == TICK_DIV-1.
//   Packet format (NBYTES+3 bytes, index 0..NBYTES+2)
//   - Byte 0: HEADER.
//   - Byte 1: seq.
//   - Bytes 2..NBYTES+1: shadow[7:0] first, i.e. LSB byte first.
//   - Byte NBYTES+2: checksum = XOR of seq and all data bytes; HEADER is excluded.
//   FSM
//   - IDLE: on sample_tick & enable go to CAPTURE.
//   - CAPTURE: shadow <= snap_d, index <= 0, checksum <= 0; go to SEND.
//   - SEND: tx_byte <= byte[index], tx_push <= 1 for one cycle, fold the byte into the checksum
//     (indices 1..NBYTES+1 only); go to WAIT.
//   - WAIT: tx_push = 0. On tx_done: if index == NBYTES+2, seq <= seq+1 (wraps mod 256) and go to
//     IDLE; else index <= index+1 and go to SEND.
//   Timing and handshake
//   - Latency: with a tick in cycle T, snap_d is sampled at the end of T+1 and the first tx_push
//     is high in cycle T+3.
//   - Never more than one outstanding push.
//   - tx_done outside WAIT is ignored; tx_done in the same cycle as tx_push is ignored.
//   Overrun and enable
//   - A sample_tick while state != IDLE is discarded, and overrun_cnt increments (saturates at 255).
//   - Ticks while enable = 0 are not counted.
//   - enable falling mid-packet: the current packet completes; no new packet starts.
//   - seq counts transmitted packets only, so discarded ticks leave no gap in seq.
// TESTING (sim with SYSTEM_FREQ=2000, TARGET_FREQ=10 -> TICK_DIV=200; uart model pulses tx_done 20 cycles after push)
//   1 Basic: DATASIZE=64, snap_d=64'h0000_0000_0000_00FF, enable=1 -> A5,00,FF,00x7,FF;
//     tx_push first high 3 cycles after the tick.
//   2 Zero checksum: snap_d=64'hAA01_2345_AA01_2345 at seq=1 -> A5,01,45,23,01,AA,45,23,01,AA,01.
//   3 Wrap: run 257 packets -> seq field goes FE,FF,00; sample_tick period is exactly 200 cycles.
//   4 Overrun: tx_done delay 30 cycles (11 bytes x ~31 cycles > 200) -> overrun_cnt steps by 1 per
//     lost tick, saturates at 255, seq stays contiguous.
//   5 Width: DATASIZE=16, snap_d=16'h1234 -> 5 bytes A5,seq,34,12,seq^34^12.
//   6 Control: enable low after byte 3 -> packet finishes, busy falls, no further pushes;
//     rst_n low mid-WAIT -> all outputs 0 at once, next packet restarts at seq 00.

Source files
------------

// File: rtl/tdc_frame_streamer.sv
// TDC snapshot streamer: divides clk10m down to the sample tick, captures the delayline
// snapshot and ships it to uart_tx as a framed packet (header, seq, data, XOR checksum).
module tdc_frame_streamer #(
  parameter int          DATASIZE    = 64,
  parameter int          SYSTEM_FREQ = 10000000,
  parameter int          TARGET_FREQ = 30,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                clk10m,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DATASIZE-1:0] snap_d,
  output logic                sample_tick,
  output logic                tx_push,
  output logic [7:0]          tx_byte,
  input  logic                tx_done,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  localparam int NBYTES   = DATASIZE / 8;
  localparam int TICK_DIV = SYSTEM_FREQ / TARGET_FREQ;
  localparam int DW       = $clog2(TICK_DIV);
  localparam int IW       = $clog2(NBYTES + 3);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 2);
  localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic                tick_q, tick_d;
  logic [DATASIZE-1:0] shadow_q, shadow_d;
  logic [IW-1:0]       index_q, index_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          seq_q, seq_d;
  logic                push_q, push_d;
  logic [7:0]          byte_q, byte_d;
  logic [7:0]          ovr_q, ovr_d;
  logic [7:0]          cur_byte;

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      tick_q   <= 1'b0;
      shadow_q <= '0;
      index_q  <= '0;
      csum_q   <= '0;
      seq_q    <= '0;
      push_q   <= 1'b0;
      byte_q   <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      shadow_q <= shadow_d;
      index_q  <= index_d;
      csum_q   <= csum_d;
      seq_q    <= seq_d;
      push_q   <= push_d;
      byte_q   <= byte_d;
      ovr_q    <= ovr_d;
    end
  end

  // Packet byte currently addressed by index: header, seq, data LSB-first, checksum.
  always_comb begin
    cur_byte = 8'h00;
    if (index_q == '0)           cur_byte = HEADER;
    else if (index_q == IW'(1))  cur_byte = seq_q;
    else if (index_q == LAST_IDX) cur_byte = csum_q;
    else begin
      for (int i = 0; i < NBYTES; i++)
        if (index_q == IW'(i + 2)) cur_byte = shadow_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    index_d  = index_q;
    csum_d   = csum_q;
    seq_d    = seq_q;
    push_d   = 1'b0;
    byte_d   = byte_q;
    ovr_d    = ovr_q;

    div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    // Registered so the tick is high exactly while the counter sits at TICK_DIV-1.
    tick_d = (div_d == DIV_MAX);

    if (tick_q && enable && state_q != S_IDLE && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;

    case (state_q)
      S_IDLE: if (tick_q && enable) state_d = S_CAPTURE;
      S_CAPTURE: begin
        shadow_d = snap_d;
        index_d  = '0;
        csum_d   = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        push_d = 1'b1;
        byte_d = cur_byte;
        if (index_q != '0 && index_q != LAST_IDX) csum_d = csum_q ^ cur_byte;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done coinciding with our own push belongs to an earlier byte; drop it.
        if (tx_done && !push_q) begin
          if (index_q == LAST_IDX) begin
            seq_d   = seq_q + 8'd1;
            state_d = S_IDLE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sample_tick = tick_q;
  assign tx_push     = push_q;
  assign tx_byte     = byte_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_tdc_frame_streamer.sv
// Directed bench: 64-bit streamer (tick every 200 cycles) and 16-bit streamer (every 40)
// each driven by a small uart_tx model that answers pushes after a programmable delay.
module tb_tdc_frame_streamer;

  logic        clk10m = 1'b0;
  always #5 clk10m = ~clk10m;

  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [63:0] snap_a = '0;
  logic [15:0] snap_b = '0;
  logic        tick_a, push_a, busy_a, done_a;
  logic        tick_b, push_b, busy_b, done_b;
  logic [7:0]  byte_a, ovr_a, byte_b, ovr_b;

  int total = 0, bad = 0, cyc = 0;
  int dly_a = 10, dly_b = 3, cnt_a = 0, cnt_b = 0;
  bit mute_b = 1'b0;
  logic [7:0] q_a[$], q_b[$];
  int pc_a[$], tk_a[$], tk_b[$];

  tdc_frame_streamer #(.DATASIZE(64), .SYSTEM_FREQ(2000), .TARGET_FREQ(10), .HEADER(8'hA5)) u_a (
    .clk10m(clk10m), .rst_n(rst_n), .enable(en_a), .snap_d(snap_a), .sample_tick(tick_a),
    .tx_push(push_a), .tx_byte(byte_a), .tx_done(done_a), .busy(busy_a), .overrun_cnt(ovr_a));

  tdc_frame_streamer #(.DATASIZE(16), .SYSTEM_FREQ(400), .TARGET_FREQ(10), .HEADER(8'hA5)) u_b (
    .clk10m(clk10m), .rst_n(rst_n), .enable(en_b), .snap_d(snap_b), .sample_tick(tick_b),
    .tx_push(push_b), .tx_byte(byte_b), .tx_done(done_b), .busy(busy_b), .overrun_cnt(ovr_b));

  // uart_tx models and byte/tick recorders, sampled 1 ns after each edge
  initial begin
    done_a = 1'b0;
    done_b = 1'b0;
    forever begin
      @(posedge clk10m); #1;
      cyc++;
      done_a = 1'b0;
      if (cnt_a > 0) begin cnt_a--; if (cnt_a == 0) done_a = 1'b1; end
      if (push_a) begin q_a.push_back(byte_a); pc_a.push_back(cyc); cnt_a = dly_a; end
      if (tick_a) tk_a.push_back(cyc);
      done_b = 1'b0;
      if (cnt_b > 0) begin cnt_b--; if (cnt_b == 0) done_b = 1'b1; end
      if (push_b) begin q_b.push_back(byte_b); if (!mute_b) cnt_b = dly_b; end
      if (tick_b) tk_b.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk10m); #2; end
  endtask

  task automatic wait_busy_a(input logic lvl, input int lim);
    int k = 0;
    while (busy_a !== lvl && k < lim) begin step(1); k++; end
    if (busy_a !== lvl) begin
      total++; bad++;
      $display("FAIL wait_busy_a: busy=%b want %b after %0d cycles", busy_a, lvl, lim);
    end
  endtask

  task automatic wait_busy_b(input logic lvl, input int lim);
    int k = 0;
    while (busy_b !== lvl && k < lim) begin step(1); k++; end
    if (busy_b !== lvl) begin
      total++; bad++;
      $display("FAIL wait_busy_b: busy=%b want %b after %0d cycles", busy_b, lvl, lim);
    end
  endtask

  task automatic run_a(input logic [63:0] s);
    snap_a = s; q_a.delete(); pc_a.delete(); tk_a.delete();
    en_a = 1'b1;
    wait_busy_a(1'b1, 450);
    en_a = 1'b0;
    wait_busy_a(1'b0, 600);
  endtask

  task automatic run_b(input logic [15:0] s);
    snap_b = s; q_b.delete();
    en_b = 1'b1;
    wait_busy_b(1'b1, 100);
    en_b = 1'b0;
    wait_busy_b(1'b0, 300);
  endtask

  task automatic test_reset;
    int rel;
    step(3);
    total += 10;
    if (tick_a !== 1'b0) begin bad++; $display("FAIL rst_tick_a: got %b want 0", tick_a); end
    if (push_a !== 1'b0) begin bad++; $display("FAIL rst_push_a: got %b want 0", push_a); end
    if (byte_a !== 8'h00) begin bad++; $display("FAIL rst_byte_a: got %h want 00", byte_a); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy_a: got %b want 0", busy_a); end
    if (ovr_a !== 8'h00) begin bad++; $display("FAIL rst_ovr_a: got %h want 00", ovr_a); end
    if (tick_b !== 1'b0) begin bad++; $display("FAIL rst_tick_b: got %b want 0", tick_b); end
    if (push_b !== 1'b0) begin bad++; $display("FAIL rst_push_b: got %b want 0", push_b); end
    if (byte_b !== 8'h00) begin bad++; $display("FAIL rst_byte_b: got %h want 00", byte_b); end
    if (busy_b !== 1'b0) begin bad++; $display("FAIL rst_busy_b: got %b want 0", busy_b); end
    if (ovr_b !== 8'h00) begin bad++; $display("FAIL rst_ovr_b: got %h want 00", ovr_b); end
    tk_a.delete(); tk_b.delete();
    rst_n = 1'b1; rel = cyc;
    step(210);
    total += 2;
    if (tk_a.size() == 0 || tk_a[0] - rel != 199) begin
      bad++; $display("FAIL first_tick_a: got %0d want 199", tk_a.size() ? tk_a[0] - rel : -1);
    end
    if (tk_b.size() == 0 || tk_b[0] - rel != 39) begin
      bad++; $display("FAIL first_tick_b: got %0d want 39", tk_b.size() ? tk_b[0] - rel : -1);
    end
  endtask

  task automatic test_basic;
    logic [7:0] want [11];
    want = '{8'hA5, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    run_a(64'h0000_0000_0000_00FF);
    total++;
    if (q_a.size() != 11) begin bad++; $display("FAIL basic_len: got %0d want 11", q_a.size()); end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (i >= q_a.size() || q_a[i] !== want[i]) begin
        bad++; $display("FAIL basic_byte%0d: got %h want %h", i, i < q_a.size() ? q_a[i] : 8'hxx, want[i]);
      end
    end
    total++;
    if (pc_a.size() == 0 || tk_a.size() == 0 || pc_a[0] - tk_a[0] != 3) begin
      bad++; $display("FAIL basic_latency: got %0d want 3",
                      (pc_a.size() && tk_a.size()) ? pc_a[0] - tk_a[0] : -1);
    end
  endtask

  task automatic test_zero_checksum;
    logic [7:0] want [11];
    want = '{8'hA5, 8'h01, 8'h45, 8'h23, 8'h01, 8'hAA, 8'h45, 8'h23, 8'h01, 8'hAA, 8'h01};
    run_a(64'hAA01_2345_AA01_2345);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (i >= q_a.size() || q_a[i] !== want[i]) begin
        bad++; $display("FAIL csum_byte%0d: got %h want %h", i, i < q_a.size() ? q_a[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int k = 0;
    logic [7:0] ws;
    q_a.delete(); tk_a.delete();
    en_a = 1'b1;
    while (q_a.size() < 257 * 11 && k < 52500) begin step(1); k++; end
    en_a = 1'b0;
    wait_busy_a(1'b0, 600);
    total++;
    if (q_a.size() != 257 * 11) begin bad++; $display("FAIL wrap_len: got %0d want %0d", q_a.size(), 257 * 11); end
    for (int p = 0; p < 257 && p * 11 + 1 < q_a.size(); p++) begin
      ws = 8'(p + 2);
      total++;
      if (q_a[p*11] !== 8'hA5 || q_a[p*11+1] !== ws) begin
        bad++; $display("FAIL wrap_seq%0d: got %h/%h want a5/%h", p, q_a[p*11], q_a[p*11+1], ws);
      end
    end
    for (int i = 1; i < tk_a.size(); i++) begin
      total++;
      if (tk_a[i] - tk_a[i-1] != 200) begin
        bad++; $display("FAIL tick_period%0d: got %0d want 200", i, tk_a[i] - tk_a[i-1]);
      end
    end
    total++;
    if (ovr_a !== 8'h00) begin bad++; $display("FAIL wrap_ovr: got %h want 00", ovr_a); end
  endtask

  task automatic test_control;
    int k = 0;
    logic [7:0] want [11];
    // seq is now 2+257 = 259 -> 03; snapshot data XORs to zero so checksum = 03
    q_a.delete();
    en_a = 1'b1;
    while (q_a.size() < 3 && k < 450) begin step(1); k++; end
    en_a = 1'b0;
    wait_busy_a(1'b0, 600);
    total += 3;
    if (q_a.size() != 11) begin bad++; $display("FAIL ctl_len: got %0d want 11", q_a.size()); end
    if (q_a.size() < 2 || q_a[1] !== 8'h03) begin bad++; $display("FAIL ctl_seq: got %h want 03", q_a.size() > 1 ? q_a[1] : 8'hxx); end
    if (q_a.size() < 11 || q_a[10] !== 8'h03) begin bad++; $display("FAIL ctl_csum: got %h want 03", q_a.size() > 10 ? q_a[10] : 8'hxx); end
    step(450);
    total += 2;
    if (q_a.size() != 11) begin bad++; $display("FAIL ctl_nopush: got %0d bytes want 11", q_a.size()); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL ctl_idle: got %b want 0", busy_a); end
    // reset while waiting on byte 1 of the next packet
    k = 0;
    en_a = 1'b1;
    while (q_a.size() < 13 && k < 450) begin step(1); k++; end
    rst_n = 1'b0;
    #1;
    total += 4;
    if (push_a !== 1'b0) begin bad++; $display("FAIL mid_rst_push: got %b want 0", push_a); end
    if (byte_a !== 8'h00) begin bad++; $display("FAIL mid_rst_byte: got %h want 00", byte_a); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
    if (tick_a !== 1'b0) begin bad++; $display("FAIL mid_rst_tick: got %b want 0", tick_a); end
    en_a = 1'b0;
    step(30);
    rst_n = 1'b1;
    want = '{8'hA5, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
    run_a(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (i >= q_a.size() || q_a[i] !== want[i]) begin
        bad++; $display("FAIL post_rst_byte%0d: got %h want %h", i, i < q_a.size() ? q_a[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_width;
    logic [7:0] w1 [5], w2 [5];
    w1 = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h26};
    w2 = '{8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h67};
    dly_b = 3;
    run_b(16'h1234);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= q_b.size() || q_b[i] !== w1[i]) begin
        bad++; $display("FAIL w16a_byte%0d: got %h want %h", i, i < q_b.size() ? q_b[i] : 8'hxx, w1[i]);
      end
    end
    run_b(16'hABCD);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= q_b.size() || q_b[i] !== w2[i]) begin
        bad++; $display("FAIL w16b_byte%0d: got %h want %h", i, i < q_b.size() ? q_b[i] : 8'hxx, w2[i]);
      end
    end
  endtask

  task automatic test_overrun;
    int want = 0, lost = 0, n;
    bit pend = 1'b0;
    logic [7:0] ws;
    total++;
    if (ovr_b !== 8'h00) begin bad++; $display("FAIL ovr_start: got %h want 00", ovr_b); end
    dly_b = 30; q_b.delete();
    en_b = 1'b1;
    for (int c = 0; c < 13000; c++) begin
      if (c == 1000) begin
        // seq continuity over the packets sent so far, despite the discarded ticks
        n = q_b.size() / 5;
        total++;
        if (n < 3) begin bad++; $display("FAIL ovr_pkts: got %0d want >=3", n); end
        for (int p = 0; p < n; p++) begin
          ws = 8'(p + 2);
          total++;
          if (q_b[p*5+1] !== ws) begin bad++; $display("FAIL ovr_seq%0d: got %h want %h", p, q_b[p*5+1], ws); end
        end
        mute_b = 1'b1;
      end
      if (pend) begin
        total++;
        if (ovr_b !== 8'(want)) begin bad++; $display("FAIL ovr_step c%0d: got %0d want %0d", c, ovr_b, want); end
        pend = 1'b0;
      end
      if (tick_b) begin
        if (busy_b && en_b) begin lost++; if (want < 255) want++; end
        pend = 1'b1;
      end
      step(1);
    end
    total += 2;
    if (lost < 256) begin bad++; $display("FAIL ovr_lost: got %0d want >=256", lost); end
    if (ovr_b !== 8'd255) begin bad++; $display("FAIL ovr_sat: got %0d want 255", ovr_b); end
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_checksum();
    test_wrap();
    test_control();
    test_width();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
